// File: rtl/pad_pkg.sv
// Shared constants and state type for the controller-pad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pad_pkg;

  // Bit positions inside one pad's 12-bit active-high button field.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;
  localparam int NUM_BTNS  = 12;

  // Bit positions inside one pad's 6-bit raw pin group.
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_AB    = 4;
  localparam int PIN_CS    = 5;
  localparam int NUM_PINS  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PHASE,
    ST_COMMIT
  } scan_state_t;

endpackage

// File: rtl/pad_scanner_if.sv
// Pad scanner bus: pin inputs, select outputs and committed scan results.
// Latency: n/a (wiring only).
// Backpressure: none; results are a pulse-qualified hold register.
interface pad_scanner_if #(
  parameter int NUM_PADS = 2
);
  logic                     scan_enable;
  logic [6*NUM_PADS-1:0]    pad_pins;
  logic [NUM_PADS-1:0]      pad_sel;
  logic [12*NUM_PADS-1:0]   buttons;
  logic [NUM_PADS-1:0]      six_button;
  logic [NUM_PADS-1:0]      pad_present;
  logic                     frame_valid;

  // master: the environment (pads + consumer); slave: the scanner.
  modport master (
    output scan_enable, pad_pins,
    input  pad_sel, buttons, six_button, pad_present, frame_valid
  );

  modport slave (
    input  scan_enable, pad_pins,
    output pad_sel, buttons, six_button, pad_present, frame_valid
  );
endinterface

// File: rtl/pad_sync.sv
// Parametrised-width 2-flop synchronizer, both stages reset to 1 (idle pin level).
// Latency: 2 clocks from d to q.
// Backpressure: none.
// Ports: clock, reset (async active-high), d (async input), q (synchronized output).
module pad_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pad_scanner.sv
// Periodic 8-phase scan of 3/6-button controller pads, committing decoded buttons.
// Latency: scan start (frame counter 0) to frame_valid is 8*SETTLE_CYCLES+1 clocks.
// Backpressure: none; results hold until the next commit, frame_valid pulses once.
// Ports: clock, reset (async active-high), bus (pad_scanner_if.slave):
//   scan_enable/pad_pins in; pad_sel, buttons, six_button, pad_present, frame_valid out.
module pad_scanner
  import pad_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int FRAME_CYCLES  = 262144
) (
  input logic          clock,
  input logic          reset,
  pad_scanner_if.slave bus
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [NUM_PADS-1:0][NUM_PINS-1:0] sync_pins;
  logic [NUM_PADS-1:0][NUM_PINS-1:0] pin_low;   // 1 = pin reads 0

  pad_sync #(.WIDTH(NUM_PINS*NUM_PADS)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.pad_pins),
    .q     (sync_pins)
  );

  assign pin_low = ~sync_pins;

  scan_state_t                       state;
  logic [2:0]                        phase;
  logic [SW-1:0]                     settle;
  logic [FW-1:0]                     frame_cnt;
  logic                              armed;
  logic                              sel_q;
  logic [NUM_PADS-1:0][NUM_BTNS-1:0] cap_btn;
  logic [NUM_PADS-1:0]               cap_present;
  logic [NUM_PADS-1:0]               cap_six;
  logic [NUM_PADS-1:0][NUM_BTNS-1:0] btn_q;
  logic [NUM_PADS-1:0]               six_q;
  logic [NUM_PADS-1:0]               present_q;
  logic                              frame_valid_q;

  // armed is low only in the first clock after reset, so the counter-0 cycle
  // coinciding with reset release never starts a scan; the first scan waits a
  // full frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase         <= 3'd0;
      settle        <= '0;
      frame_cnt     <= '0;
      armed         <= 1'b0;
      sel_q         <= 1'b1;
      cap_btn       <= '0;
      cap_present   <= '0;
      cap_six       <= '0;
      btn_q         <= '0;
      six_q         <= '0;
      present_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      armed         <= 1'b1;
      frame_cnt     <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (armed && bus.scan_enable && frame_cnt == '0) begin
            state  <= ST_PHASE;
            phase  <= 3'd0;
            settle <= '0;
            sel_q  <= 1'b1;
          end
        end

        ST_PHASE: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
              case (phase)
                3'd0: begin
                  cap_btn[p][BTN_UP]    <= pin_low[p][PIN_UP];
                  cap_btn[p][BTN_DOWN]  <= pin_low[p][PIN_DOWN];
                  cap_btn[p][BTN_LEFT]  <= pin_low[p][PIN_LEFT];
                  cap_btn[p][BTN_RIGHT] <= pin_low[p][PIN_RIGHT];
                  cap_btn[p][BTN_B]     <= pin_low[p][PIN_AB];
                  cap_btn[p][BTN_C]     <= pin_low[p][PIN_CS];
                end
                3'd1: begin
                  cap_btn[p][BTN_A]     <= pin_low[p][PIN_AB];
                  cap_btn[p][BTN_START] <= pin_low[p][PIN_CS];
                  // A connected pad grounds left/right while select is low.
                  cap_present[p]        <= pin_low[p][PIN_LEFT] & pin_low[p][PIN_RIGHT];
                end
                3'd5: begin
                  // 6-button pads drive all four directions low on the third low phase.
                  cap_six[p] <= pin_low[p][PIN_UP] & pin_low[p][PIN_DOWN] &
                                pin_low[p][PIN_LEFT] & pin_low[p][PIN_RIGHT];
                end
                3'd6: begin
                  cap_btn[p][BTN_Z]    <= cap_six[p] & pin_low[p][PIN_UP];
                  cap_btn[p][BTN_Y]    <= cap_six[p] & pin_low[p][PIN_DOWN];
                  cap_btn[p][BTN_X]    <= cap_six[p] & pin_low[p][PIN_LEFT];
                  cap_btn[p][BTN_MODE] <= cap_six[p] & pin_low[p][PIN_RIGHT];
                end
                default: ;
              endcase
            end

            if (phase == 3'd7) begin
              // Results become visible during the single COMMIT clock.
              state         <= ST_COMMIT;
              sel_q         <= 1'b1;
              frame_valid_q <= 1'b1;
              present_q     <= cap_present;
              for (int p = 0; p < NUM_PADS; p++) begin
                btn_q[p] <= cap_present[p] ? cap_btn[p] : '0;
                six_q[p] <= cap_present[p] & cap_six[p];
              end
            end else begin
              phase <= phase + 3'd1;
              // Next phase is odd (select low) when the current one is even.
              sel_q <= phase[0];
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end

        ST_COMMIT: begin
          state <= ST_IDLE;
          phase <= 3'd0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pad_sel     = {NUM_PADS{sel_q}};
  assign bus.buttons     = btn_q;
  assign bus.six_button  = six_q;
  assign bus.pad_present = present_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: doc/pad_scanner.md
PAD_SCANNER -- requirements
Module: pad_scanner

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of controller ports (1..4).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, clocks per select phase (>=4).
REQ-003 SHALL have parameter FRAME_CYCLES, default 262144, scan period in clocks (>8*SETTLE_CYCLES+2).
REQ-004 SHALL have port clock, input, 1, sole clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port scan_enable, input, 1: high permits a scan to start at frame boundary.
REQ-007 SHALL have port pad_pins, input, 6*NUM_PADS, raw active-low pins; pad p bits 6p+0..5 = up, down, left, right, a_b, c_s.
REQ-008 SHALL have port pad_sel, output, NUM_PADS, select line per pad; all bits driven identically.
REQ-009 SHALL have port buttons, output, 12*NUM_PADS, active-high state; pad p bits 12p+0..11 = Up, Down, Left, Right, A, B, C, Start, X, Y, Z, Mode.
REQ-010 SHALL have port six_button, output, NUM_PADS: pad identified as 6-button in last scan.
REQ-011 SHALL have port pad_present, output, NUM_PADS: pad detected in last scan.
REQ-012 SHALL have port frame_valid, output, 1: one-clock pulse when results commit.

Function
REQ-013 pad_pins SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A free-running frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; a scan SHALL start in the cycle the counter is 0 if scan_enable is high and state is IDLE.
REQ-015 States SHALL be IDLE, PHASE, COMMIT; PHASE carries a 3-bit phase index 0..7 and a settle counter.
REQ-016 pad_sel SHALL be 1 in IDLE, COMMIT and even phases, 0 in odd phases.
REQ-017 Each phase SHALL last exactly SETTLE_CYCLES clocks; synchronized pins SHALL be sampled in its last clock, then phase advances; after phase 7 sample, state goes to COMMIT.
REQ-018 Phase 0 sample SHALL capture Up, Down, Left, Right, B (a_b), C (c_s).
REQ-019 Phase 1 sample SHALL capture A (a_b), Start (c_s); pad present iff left and right pins both read 0.
REQ-020 Phase 5 sample SHALL set six-button iff up, down, left, right pins all read 0.
REQ-021 Phase 6 sample SHALL capture Z (up), Y (down), X (left), Mode (right) when six-button set, else these bits SHALL be 0.
REQ-022 Phases 2, 3, 4, 7 samples SHALL be discarded.
REQ-023 A captured button SHALL be 1 iff its pin read 0.
REQ-024 COMMIT SHALL last one clock: buttons, six_button, pad_present update simultaneously, frame_valid=1, next state IDLE.
REQ-025 A pad not present SHALL commit buttons=0 and six_button=0.
REQ-026 Scan duration from start to frame_valid SHALL be 8*SETTLE_CYCLES+1 clocks.
REQ-027 scan_enable falling mid-scan SHALL NOT abort; the scan completes and commits.
REQ-028 Outputs SHALL hold last committed values between commits; pads are processed independently in the same phases.

Reset
REQ-029 Reset SHALL force: state IDLE, phase 0, frame counter 0, pad_sel all 1, buttons 0, six_button 0, pad_present 0, frame_valid 0, synchronizer flops 1.
REQ-030 Reset asserted mid-scan SHALL discard partial captures; first scan after release starts at the next counter-0 cycle.

Structure
REQ-031 Package pad_pkg SHALL hold button bit-index constants, pin index constants, and the state type.
REQ-032 Sub-module pad_sync (parametrised-width 2-flop synchronizer, reset to 1) SHALL be used for pad_pins.

Verification (SETTLE_CYCLES=4, FRAME_CYCLES=128)
REQ-033 3-button model, Up+A held, NUM_PADS=2 pad 0 only -> pad 0 buttons=0x011, six_button=0, present=01, pad 1 buttons=0x000.
REQ-034 6-button model, X+Start held -> buttons=0x180, six_button=1, frame_valid 33 clocks after scan start.
REQ-035 All pins high (no pad) -> buttons=0, present=0, six_button=0, pad_sel stays 1 outside scans.
REQ-036 scan_enable low -> no frame_valid for 3 frames; drop during phase 3 -> scan completes, one frame_valid.
REQ-037 reset at phase 4 -> all outputs 0, pad_sel=1 same cycle; next frame_valid exactly 128+33 clocks after release edge counter restart.
REQ-038 NUM_PADS=4 mixed 3/6-button/absent -> per-pad fields independent and correct.
